// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the DMA preload scheduler.
//   state_t    : scheduler FSM states
//   CNT_W_DEF  : default descriptor count width
//   max_count  : largest legal word count for a buffer of 2^buf_addr_w words
package dma_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_RELEASE,
        S_FAULT
    } state_t;

    localparam int CNT_W_DEF = 17;

    // A full buffer is a legal transfer, so the limit is 2^buf_addr_w itself.
    function automatic logic [31:0] max_count(input int buf_addr_w);
        max_count = 32'd1 << buf_addr_w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req : request vector, one bit per requester
//   ptr : highest-priority index this cycle (search starts here, wraps upward)
//   hit : at least one request is set
//   idx : index of the first set bit found from ptr upward with wrap
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dma_preload_sched.sv
// Round-robin scheduler sharing one DMA preload engine between NUM_REQ
// requesters. Latches one descriptor per grant, validates it, drives the
// engine's level request and tracks completion with a watchdog.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/base/count: per-requester descriptors (packed, requester i at
//                         [i*W +: W]); sampled only in the grant cycle
//   req_grant/done/err  : one-hot 1-cycle pulses per requester
//   dma_preload_*       : engine interface (req level, base, count, done)
//   active_id           : current/last granted requester (steers write port)
//   busy, fault         : not-idle flag, sticky watchdog fault
//   dbg_state           : FSM state for observation
//
// Engine handshake (four-phase): req rises only while done is low; the
// engine raises done; req falls; the engine drops done; only then is the
// transfer complete. A done seen while idle belongs to an abandoned burst
// (reset mid-transfer) and simply blocks the next issue until it clears.
module dma_preload_sched
    import dma_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int BUF_ADDR_W  = 13,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_base,
    input  logic [NUM_REQ*CNT_W-1:0]   req_count,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       dma_preload_req,
    output logic [ADDR_W-1:0]          dma_preload_base,
    output logic [CNT_W-1:0]           dma_preload_count,
    input  logic                       dma_preload_done,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       busy,
    output logic                       fault,
    output state_t                     dbg_state
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CW1  = CNT_W + 1;
    localparam logic [CNT_W:0] MAX_CNT = CW1'(max_count(BUF_ADDR_W));

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [WD_W-1:0]     wd;
    logic                pick_hit;
    logic [ID_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]   sel_base;
    logic [CNT_W-1:0]    sel_count;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [NUM_REQ-1:0]  act_oh;
    logic [ID_W-1:0]     next_ptr;
    logic                cnt_bad;

    rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // Constant-index mux keeps the descriptor select free of wide index math.
    always_comb begin
        sel_base  = '0;
        sel_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                sel_base  = req_base[i*ADDR_W +: ADDR_W];
                sel_count = req_count[i*CNT_W +: CNT_W];
            end
        end
    end

    assign pick_oh  = NUM_REQ'(1) << pick_idx;
    assign act_oh   = NUM_REQ'(1) << active_id;
    assign next_ptr = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;
    // Compared one bit wider so a count of exactly 2^BUF_ADDR_W is legal.
    assign cnt_bad  = (dma_preload_count == '0) ||
                      ({1'b0, dma_preload_count} > MAX_CNT);

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            rr_ptr            <= '0;
            wd                <= '0;
            req_grant         <= '0;
            req_done          <= '0;
            req_err           <= '0;
            dma_preload_req   <= 1'b0;
            dma_preload_base  <= '0;
            dma_preload_count <= '0;
            active_id         <= '0;
            fault             <= 1'b0;
        end else begin
            req_grant <= '0;
            req_done  <= '0;
            req_err   <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_hit && !dma_preload_done) begin
                        dma_preload_base  <= sel_base;
                        dma_preload_count <= sel_count;
                        active_id         <= pick_idx;
                        req_grant         <= pick_oh;
                        state             <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cnt_bad) begin
                        req_err <= act_oh;
                        rr_ptr  <= next_ptr;
                        state   <= S_IDLE;
                    end else begin
                        dma_preload_req <= 1'b1;
                        wd              <= '0;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dma_preload_done) begin
                        dma_preload_req <= 1'b0;
                        state           <= S_RELEASE;
                    end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        fault           <= 1'b1;
                        dma_preload_req <= 1'b0;
                        state           <= S_FAULT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!dma_preload_done) begin
                        req_done <= act_oh;
                        rr_ptr   <= next_ptr;
                        state    <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_preload_sched.sv
// Directed bench for dma_preload_sched (NUM_REQ=2, BUF_ADDR_W=13,
// TIMEOUT_CYC=50). The engine side is driven directly by the sequence.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_dma_preload_sched;
    import dma_sched_pkg::*;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int BW = 13;
    localparam int CW = 17;
    localparam int TO = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [AW-1:0]     base_a [NR];
    logic [CW-1:0]     cnt_a  [NR];
    logic [NR*AW-1:0]  req_base;
    logic [NR*CW-1:0]  req_count;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic              dma_preload_req;
    logic [AW-1:0]     dma_preload_base;
    logic [CW-1:0]     dma_preload_count;
    logic              dma_preload_done;
    logic              active_id;
    logic              busy;
    logic              fault;
    state_t            dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    assign req_base  = {base_a[1], base_a[0]};
    assign req_count = {cnt_a[1], cnt_a[0]};

    dma_preload_sched #(
        .NUM_REQ(NR), .ADDR_W(AW), .BUF_ADDR_W(BW), .CNT_W(CW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_base          (req_base),
        .req_count         (req_count),
        .req_grant         (req_grant),
        .req_done          (req_done),
        .req_err           (req_err),
        .dma_preload_req   (dma_preload_req),
        .dma_preload_base  (dma_preload_base),
        .dma_preload_count (dma_preload_count),
        .dma_preload_done  (dma_preload_done),
        .active_id         (active_id),
        .busy              (busy),
        .fault             (fault),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_desc(input logic id, input logic [AW-1:0] b, input logic [CW-1:0] c);
        base_a[id]    = b;
        cnt_a[id]     = c;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_grant();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (|req_grant) begin
                seen = 1'b1;
                break;
            end
        end
        check("grant_seen", 32'(seen), 32'd1);
    endtask

    // Grant -> issue -> engine done after dly cycles -> release -> req_done.
    task automatic serve(input logic id, input int dly, input bit drop,
                         input logic [AW-1:0] eb, input logic [CW-1:0] ec);
        wait_grant();
        check("grant_oh",   32'(req_grant), 32'(2'b01 << id));
        check("grant_id",   32'(active_id), 32'(id));
        check("grant_base", 32'(dma_preload_base), 32'(eb));
        check("grant_cnt",  32'(dma_preload_count), 32'(ec));
        check("req_pre",    32'(dma_preload_req), 32'd0);
        if (drop) req_valid[id] = 1'b0;
        tick();
        check("req_rise",   32'(dma_preload_req), 32'd1);
        check("grant_pulse", 32'(req_grant), 32'd0);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("req_hold", 32'(dma_preload_req), 32'd1);
            check("base_hold", 32'(dma_preload_base), 32'(eb));
        end
        dma_preload_done = 1'b1;
        tick();
        check("req_drop",   32'(dma_preload_req), 32'd0);
        tick();
        check("rel_wait",   32'(req_done), 32'd0);
        check("rel_busy",   32'(busy), 32'd1);
        dma_preload_done = 1'b0;
        tick();
        check("done_oh",    32'(req_done), 32'(2'b01 << id));
        check("idle_busy",  32'(busy), 32'd0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        bit any;
        req_valid        = '0;
        base_a[0]        = '0;
        base_a[1]        = '0;
        cnt_a[0]         = '0;
        cnt_a[1]         = '0;
        dma_preload_done = 1'b0;
        do_reset();

        // Reset state
        check("rst_grant", 32'(req_grant), 32'd0);
        check("rst_req",   32'(dma_preload_req), 32'd0);
        check("rst_base",  32'(dma_preload_base), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_id",    32'(active_id), 32'd0);

        // Single request
        set_desc(1'b0, 16'h0100, 17'd16);
        serve(1'b0, 16, 1'b1, 16'h0100, 17'd16);
        tick();
        check("done_pulse", 32'(req_done), 32'd0);

        // Round-robin: both held valid; reset restores rr_ptr to 0
        do_reset();
        set_desc(1'b0, 16'h1000, 17'd4);
        set_desc(1'b1, 16'h2000, 17'd4);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            serve(e[0], 2, 1'b0, e[0] ? 16'h2000 : 16'h1000, 17'd4);
        end
        req_valid = '0;
        tick();

        // Illegal descriptors on requester 1
        do_reset();
        set_desc(1'b1, 16'h0200, 17'd0);
        wait_grant();
        check("err0_grant", 32'(req_grant), 32'h2);
        req_valid[1] = 1'b0;
        tick();
        check("err0_err",  32'(req_err), 32'h2);
        check("err0_req",  32'(dma_preload_req), 32'd0);
        check("err0_busy", 32'(busy), 32'd0);
        tick();
        check("err0_pulse", 32'(req_err), 32'd0);
        set_desc(1'b1, 16'h0200, 17'd8193);
        wait_grant();
        check("err1_grant", 32'(req_grant), 32'h2);
        req_valid[1] = 1'b0;
        tick();
        check("err1_err",  32'(req_err), 32'h2);
        check("err1_req",  32'(dma_preload_req), 32'd0);
        set_desc(1'b1, 16'h0200, 17'd8192);
        serve(1'b1, 3, 1'b1, 16'h0200, 17'd8192);
        check("max_err", 32'(req_err), 32'd0);

        // Done held high after req drops, with requester 0 pending again
        do_reset();
        set_desc(1'b0, 16'h0400, 17'd8);
        wait_grant();
        req_valid[0] = 1'b0;
        tick();
        check("st_req", 32'(dma_preload_req), 32'd1);
        dma_preload_done = 1'b1;
        tick();
        check("st_drop", 32'(dma_preload_req), 32'd0);
        req_valid[0] = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (|req_grant || dma_preload_req || |req_done) any = 1'b1;
        end
        check("st_blocked", 32'(any), 32'd0);
        dma_preload_done = 1'b0;
        tick();
        check("st_done", 32'(req_done), 32'h1);
        check("st_nogrant", 32'(req_grant), 32'd0);
        tick();
        check("st_regrant", 32'(req_grant), 32'h1);
        req_valid[0] = 1'b0;
        tick();
        check("st_rereq", 32'(dma_preload_req), 32'd1);
        dma_preload_done = 1'b1;
        tick();
        dma_preload_done = 1'b0;
        tick();
        tick();

        // Watchdog: engine never answers
        do_reset();
        set_desc(1'b0, 16'h0600, 17'd4);
        wait_grant();
        req_valid[0] = 1'b0;
        tick();
        check("wd_req", 32'(dma_preload_req), 32'd1);
        for (int i = 0; i < TO - 1; i++) tick();
        check("wd_pre_fault", 32'(fault), 32'd0);
        check("wd_pre_req",   32'(dma_preload_req), 32'd1);
        tick();
        check("wd_fault", 32'(fault), 32'd1);
        check("wd_req0",  32'(dma_preload_req), 32'd0);
        check("wd_busy",  32'(busy), 32'd1);
        check("wd_state", 32'(dbg_state), 32'(S_FAULT));
        req_valid[0] = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (|req_grant) any = 1'b1;
        end
        check("wd_nogrant", 32'(any), 32'd0);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wd_rst_fault", 32'(fault), 32'd0);
        check("wd_rst_busy",  32'(busy), 32'd0);
        check("wd_rst_base",  32'(dma_preload_base), 32'd0);
        check("wd_rst_cnt",   32'(dma_preload_count), 32'd0);

        // Reset mid-transfer, stale done afterwards
        set_desc(1'b0, 16'h0500, 17'd8);
        wait_grant();
        req_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        check("mr_issue", 32'(dbg_state), 32'(S_ISSUE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req",  32'(dma_preload_req), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_base", 32'(dma_preload_base), 32'd0);
        check("mr_id",   32'(active_id), 32'd0);
        dma_preload_done = 1'b1;
        set_desc(1'b1, 16'h0300, 17'd32);
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (|req_grant) any = 1'b1;
        end
        check("mr_stale", 32'(any), 32'd0);
        dma_preload_done = 1'b0;
        serve(1'b1, 2, 1'b1, 16'h0300, 17'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
